// File: rtl/riscv_pkg.sv
// Shared RV32I opcode, sequencer state and datapath select encodings for the
// multi-cycle control path.
package riscv_pkg;

   typedef enum logic [6:0] {
      OP_R     = 7'b0110011,
      OP_I     = 7'b0010011,
      OP_LOAD  = 7'b0000011,
      OP_S     = 7'b0100011,
      OP_B     = 7'b1100011,
      OP_JAL   = 7'b1101111,
      OP_JALR  = 7'b1100111,
      OP_LUI   = 7'b0110111,
      OP_AUIPC = 7'b0010111
   } instruction_type;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_BRANCH, S_WRITEBACK, S_ERROR
   } state_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_S, CLS_B, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_BAD
   } op_class_t;

   localparam logic [1:0] PC_SEL_PC4    = 2'd0;
   localparam logic [1:0] PC_SEL_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SEL_ALU    = 2'd2;

   localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
   localparam logic [1:0] WB_SEL_MEM    = 2'd1;
   localparam logic [1:0] WB_SEL_PC4    = 2'd2;
   localparam logic [1:0] WB_SEL_IMM    = 2'd3;

   localparam logic [1:0] ALU_A_RS1 = 2'd0;
   localparam logic [1:0] ALU_A_PC  = 2'd1;
   localparam logic [1:0] ALU_B_RS2 = 2'd0;
   localparam logic [1:0] ALU_B_IMM = 2'd1;

   function automatic op_class_t classify(input logic [6:0] op);
      case (op)
         OP_R:     return CLS_R;
         OP_I:     return CLS_I;
         OP_LOAD:  return CLS_LOAD;
         OP_S:     return CLS_S;
         OP_B:     return CLS_B;
         OP_JAL:   return CLS_JAL;
         OP_JALR:  return CLS_JALR;
         OP_LUI:   return CLS_LUI;
         OP_AUIPC: return CLS_AUIPC;
         default:  return CLS_BAD;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting and flags the cycle on which
// the wait budget runs out without a response.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic active_i,
   input  logic ready_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A response on the final budget cycle still counts, so ready masks expiry.
   assign expired_o = active_i && !ready_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = '0;
      if (active_i && !ready_i) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/alu_sequencer_fsm.sv
// Multi-cycle RV32I control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, steering the shared ALU and memory port.
module alu_sequencer_fsm
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  op_code,
   input  logic [31:0] alu_result,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        alu_out_we,
   output logic        rf_write,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic [1:0]  alu_a_sel,
   output logic [1:0]  alu_b_sel,
   output logic [6:0]  alu_op,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        error
);

   state_t    state_q, state_d;
   op_class_t cls_q, cls_d;
   logic      taken_q, taken_d;
   logic      wait_active, expired;

   assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .active_i  (wait_active),
      .ready_i   (mem_ready),
      .expired_o (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cls_q   <= CLS_BAD;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         taken_q <= taken_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      taken_d = taken_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (expired) state_d = S_ERROR;
         end
         S_DECODE: begin
            cls_d   = classify(op_code);
            state_d = (classify(op_code) == CLS_BAD) ? S_ERROR : S_EXECUTE;
         end
         S_EXECUTE: begin
            case (cls_q)
               CLS_LOAD, CLS_S: state_d = S_MEM;
               CLS_B: begin
                  taken_d = |alu_result;
                  state_d = S_BRANCH;
               end
               default: state_d = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            if (mem_ready)    state_d = (cls_q == CLS_S) ? S_FETCH : S_WRITEBACK;
            else if (expired) state_d = S_ERROR;
         end
         S_BRANCH, S_WRITEBACK: state_d = S_FETCH;
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_ERROR;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      alu_out_we = 1'b0;
      rf_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = PC_SEL_PC4;
      alu_a_sel  = ALU_A_RS1;
      alu_b_sel  = ALU_B_RS2;
      alu_op     = 7'd0;
      wb_sel     = WB_SEL_ALUOUT;
      error      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         S_EXECUTE: begin
            alu_op     = op_code;
            alu_out_we = 1'b1;
            case (cls_q)
               CLS_I, CLS_LOAD, CLS_S, CLS_JALR: alu_b_sel = ALU_B_IMM;
               CLS_JAL, CLS_AUIPC: begin
                  alu_a_sel = ALU_A_PC;
                  alu_b_sel = ALU_B_IMM;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (cls_q == CLS_S);
            pc_write = (cls_q == CLS_S) && mem_ready;
         end
         // Taken target is pc+imm straight off the ALU, not the compare result.
         S_BRANCH: begin
            alu_op    = OP_AUIPC;
            alu_a_sel = ALU_A_PC;
            alu_b_sel = ALU_B_IMM;
            pc_write  = 1'b1;
            pc_sel    = taken_q ? PC_SEL_ALU : PC_SEL_PC4;
         end
         S_WRITEBACK: begin
            rf_write = 1'b1;
            pc_write = 1'b1;
            case (cls_q)
               CLS_LOAD: wb_sel = WB_SEL_MEM;
               CLS_JAL, CLS_JALR: begin
                  wb_sel = WB_SEL_PC4;
                  pc_sel = PC_SEL_ALUOUT;
               end
               CLS_LUI:  wb_sel = WB_SEL_IMM;
               default:  wb_sel = WB_SEL_ALUOUT;
            endcase
         end
         S_ERROR: error = 1'b1;
         default: ;
      endcase
      retire = pc_write;
   end

endmodule
